pipeline_hazard_sequencer: RTL and testbench
============================================

Name: pipeline_hazard_sequencer

Overview:
- Central stall/flush/sequencing controller for the 5-stage pipeline. It sits beside the decode/execute boundary and drives the PC, IF/ID and ID/EX pipeline-register controls.
- Detects load-use hazards that forwarding into the execute stage cannot cover, and flushes on taken jumps.
- Sequences two-iteration instructions (PUSH/POP/CALL/RET/RTI second pass), with ScndIteration driven into the control word.
- Sequences the interrupt entry: push PC, push flags, load vector.

Parameters:
- LOAD_USE_STALLS, 1: number of bubbles inserted per load-use hazard; legal range 1..3.

Ports:
- CLK  input  1  clock, all state on rising edge
- Reset  input  1  synchronous, active-low reset
- ExMemRead  input  1  instruction in EX reads memory (LDD/POP/RET/RTI)
- ExWB  input  1  instruction in EX writes back Rdst
- ExRdstAddress  input  3  Rdst address of instruction in EX
- ExJumpTaken  input  1  EX resolved a taken jump/call (JMP or satisfied JC/JN/JZ)
- IdValid  input  1  ID holds a real (non-bubble) instruction
- IdUsesRsrc  input  1  ID instruction reads Rsrc
- IdUsesRdst  input  1  ID instruction reads Rdst
- IdRsrcAddress  input  3  Rsrc address in ID
- IdRdstAddress  input  3  Rdst address in ID
- IdTwoCycle  input  1  ID instruction needs a second iteration
- IntReq  input  1  external interrupt request, level or pulse
- PcStall  output  1  hold PC
- IfIdStall  output  1  hold IF/ID register
- IfIdFlush  output  1  clear IF/ID to bubble
- IdExBubble  output  1  load bubble (all Ctrl zero) into ID/EX
- ScndIteration  output  1  ID instruction is in its second pass
- IntPushPC  output  1  memory stage pushes return PC
- IntPushFlags  output  1  memory stage pushes CF/NF/ZF
- IntLoadVector  output  1  fetch loads the interrupt vector into PC
- IntAck  output  1  one-cycle acknowledge

Behaviour:
- States: RUN, LU_WAIT, SECOND, INT_PC, INT_FLAGS, INT_VEC. Encoding is free.
- Outputs are combinational from state and current inputs. Every output is 0 while Reset=0.
- Reset low: state is RUN, stall counter 0, interrupt pending 0. This applies mid-sequence too; an in-progress interrupt entry is abandoned and no IntAck is issued.
- hazard = ExMemRead & ExWB & IdValid & ((IdUsesRsrc & IdRsrcAddress==ExRdstAddress) | (IdUsesRdst & IdRdstAddress==ExRdstAddress)).
- RUN priority, highest first:
  1. ExJumpTaken: IfIdFlush=1 and IdExBubble=1 this cycle; stay RUN; hazard and two-cycle logic are suppressed.
  2. hazard: PcStall=IfIdStall=IdExBubble=1. If LOAD_USE_STALLS>1, load counter=LOAD_USE_STALLS-1 and go to LU_WAIT; otherwise stay RUN.
  3. IdTwoCycle & IdValid: PcStall=IfIdStall=1 with ScndIteration=0 (the first pass proceeds to EX); next state SECOND.
  4. pending & IdValid: IfIdFlush=1 and PcStall=1; pending cleared; next state INT_PC.
- LU_WAIT: PcStall=IfIdStall=IdExBubble=1; counter decrements. Return to RUN after the cycle in which counter==1. ExJumpTaken cannot occur here because EX holds a bubble.
- SECOND: ScndIteration=1, no stall, and IF/ID advances. Return to RUN. A hazard is not re-evaluated in SECOND.
- INT_PC: IntPushPC=1, PcStall=1, IfIdFlush=1. Next state INT_FLAGS.
- INT_FLAGS: IntPushFlags=1, PcStall=1, IfIdFlush=1. Next state INT_VEC.
- INT_VEC: IntLoadVector=1, IntAck=1, IfIdFlush=1. Return to RUN.
- pending flag:
  - Set on any cycle with IntReq=1.
  - Cleared on acceptance.
  - IntReq during an interrupt sequence re-sets pending, and that request is serviced after returning to RUN.
  - Simultaneous set and clear: set wins.
- An interrupt is never accepted while in SECOND, so a two-iteration instruction is atomic.
- Total interrupt entry latency from acceptance to IntAck is 3 cycles.

Optional Feature:
- Macro INT_SEQ_EN.
- Defined: interrupt states and pending flag are implemented as above.
- Undefined:
  - IntReq is ignored.
  - INT_PC, INT_FLAGS and INT_VEC do not exist.
  - IntPushPC, IntPushFlags, IntLoadVector and IntAck are tied to 0.
  - All other behaviour is identical.

Test Plan:
- Load-use, LOAD_USE_STALLS=1: ExMemRead=ExWB=1, ExRdstAddress=3, IdUsesRsrc=1, IdRsrcAddress=3 -> PcStall/IfIdStall/IdExBubble=1 for exactly 1 cycle. Repeat with IdRsrcAddress=4 -> no stall.
- LOAD_USE_STALLS=3 with the same hazard -> stall/bubble held 3 consecutive cycles, then RUN.
- Jump flush: ExJumpTaken=1 together with a hazard and IdTwoCycle=1 -> only IfIdFlush=IdExBubble=1, PcStall=0, next state RUN.
- Two-cycle: IdTwoCycle=IdValid=1 -> cycle N: PcStall=1, ScndIteration=0; cycle N+1: ScndIteration=1, PcStall=0; an IntReq pulse at N is held until N+2, then IntPushPC.
- Interrupt (INT_SEQ_EN): IntReq pulse in RUN -> IntPushPC, IntPushFlags, IntLoadVector+IntAck on 3 consecutive cycles. Reset=0 asserted during INT_FLAGS -> all outputs 0, no IntAck, RUN afterwards.
- Without INT_SEQ_EN: IntReq=1 held for 10 cycles -> the four interrupt outputs remain 0.

Source files
------------

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush/sequencing controller at the decode/execute boundary of the 5-stage pipeline.
// Define INT_SEQ_EN to build the interrupt entry sequence and the pending-request flag.
module pipeline_hazard_sequencer #(
    parameter int unsigned LOAD_USE_STALLS = 1
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       ExMemRead,
    input  logic       ExWB,
    input  logic [2:0] ExRdstAddress,
    input  logic       ExJumpTaken,
    input  logic       IdValid,
    input  logic       IdUsesRsrc,
    input  logic       IdUsesRdst,
    input  logic [2:0] IdRsrcAddress,
    input  logic [2:0] IdRdstAddress,
    input  logic       IdTwoCycle,
    input  logic       IntReq,
    output logic       PcStall,
    output logic       IfIdStall,
    output logic       IfIdFlush,
    output logic       IdExBubble,
    output logic       ScndIteration,
    output logic       IntPushPC,
    output logic       IntPushFlags,
    output logic       IntLoadVector,
    output logic       IntAck
);

`ifdef INT_SEQ_EN
    typedef enum logic [2:0] {
        StRun, StLuWait, StSecond, StIntPc, StIntFlags, StIntVec
    } state_e;
`else
    typedef enum logic [1:0] {
        StRun, StLuWait, StSecond
    } state_e;
`endif

    // Remaining bubbles after the first one, loaded on entry to StLuWait.
    localparam logic [1:0] LuLoad = 2'(LOAD_USE_STALLS - 1);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       hazard;

    assign hazard = ExMemRead & ExWB & IdValid &
                    ((IdUsesRsrc & (IdRsrcAddress == ExRdstAddress)) |
                     (IdUsesRdst & (IdRdstAddress == ExRdstAddress)));

`ifdef INT_SEQ_EN
    logic pending_q, pending_d;
    logic accept;

    // A new request in the same cycle as acceptance must not be lost.
    always_comb begin
        pending_d = pending_q;
        if (accept) pending_d = 1'b0;
        if (IntReq) pending_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) pending_q <= 1'b0;
        else        pending_q <= pending_d;
    end
`else
    logic unused_int_req;
    assign unused_int_req = IntReq;
`endif

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= StRun;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PcStall       = 1'b0;
        IfIdStall     = 1'b0;
        IfIdFlush     = 1'b0;
        IdExBubble    = 1'b0;
        ScndIteration = 1'b0;
        IntPushPC     = 1'b0;
        IntPushFlags  = 1'b0;
        IntLoadVector = 1'b0;
        IntAck        = 1'b0;
`ifdef INT_SEQ_EN
        accept        = 1'b0;
`endif
        case (state_q)
            StRun: begin
                if (ExJumpTaken) begin
                    IfIdFlush  = 1'b1;
                    IdExBubble = 1'b1;
                end else if (hazard) begin
                    PcStall    = 1'b1;
                    IfIdStall  = 1'b1;
                    IdExBubble = 1'b1;
                    if (LOAD_USE_STALLS > 1) begin
                        cnt_d   = LuLoad;
                        state_d = StLuWait;
                    end
                end else if (IdTwoCycle && IdValid) begin
                    // First pass moves on to EX while ID holds for the second pass.
                    PcStall   = 1'b1;
                    IfIdStall = 1'b1;
                    state_d   = StSecond;
`ifdef INT_SEQ_EN
                end else if (pending_q && IdValid) begin
                    IfIdFlush = 1'b1;
                    PcStall   = 1'b1;
                    accept    = Reset;
                    state_d   = StIntPc;
`endif
                end
            end
            StLuWait: begin
                PcStall    = 1'b1;
                IfIdStall  = 1'b1;
                IdExBubble = 1'b1;
                cnt_d      = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) state_d = StRun;
            end
            StSecond: begin
                ScndIteration = 1'b1;
                state_d       = StRun;
            end
`ifdef INT_SEQ_EN
            StIntPc: begin
                IntPushPC = 1'b1;
                PcStall   = 1'b1;
                IfIdFlush = 1'b1;
                state_d   = StIntFlags;
            end
            StIntFlags: begin
                IntPushFlags = 1'b1;
                PcStall      = 1'b1;
                IfIdFlush    = 1'b1;
                state_d      = StIntVec;
            end
            StIntVec: begin
                IntLoadVector = 1'b1;
                IntAck        = 1'b1;
                IfIdFlush     = 1'b1;
                state_d       = StRun;
            end
`endif
            default: state_d = StRun;
        endcase

        // Outputs are forced quiet for the whole reset-low cycle.
        if (!Reset) begin
            PcStall       = 1'b0;
            IfIdStall     = 1'b0;
            IfIdFlush     = 1'b0;
            IdExBubble    = 1'b0;
            ScndIteration = 1'b0;
            IntPushPC     = 1'b0;
            IntPushFlags  = 1'b0;
            IntLoadVector = 1'b0;
            IntAck        = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer; one instance per bubble count (1 and 3).
// Interrupt scenarios follow the INT_SEQ_EN build of the design.
module tb_pipeline_hazard_sequencer;

    localparam logic [8:0] PS = 9'h100;
    localparam logic [8:0] IS = 9'h080;
    localparam logic [8:0] IF = 9'h040;
    localparam logic [8:0] BB = 9'h020;
    localparam logic [8:0] SI = 9'h010;
    localparam logic [8:0] PP = 9'h008;
    localparam logic [8:0] PF = 9'h004;
    localparam logic [8:0] LV = 9'h002;
    localparam logic [8:0] AK = 9'h001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_mem_read, ex_wb, ex_jump, id_valid, id_uses_rsrc, id_uses_rdst;
    logic       id_two_cycle, int_req;
    logic [2:0] ex_rdst, id_rsrc, id_rdst;
    wire  [8:0] out1, out3;
    logic [8:0] exp;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(.LOAD_USE_STALLS(1)) u_dut1 (
        .CLK(clk), .Reset(rst_n), .ExMemRead(ex_mem_read), .ExWB(ex_wb),
        .ExRdstAddress(ex_rdst), .ExJumpTaken(ex_jump), .IdValid(id_valid),
        .IdUsesRsrc(id_uses_rsrc), .IdUsesRdst(id_uses_rdst), .IdRsrcAddress(id_rsrc),
        .IdRdstAddress(id_rdst), .IdTwoCycle(id_two_cycle), .IntReq(int_req),
        .PcStall(out1[8]), .IfIdStall(out1[7]), .IfIdFlush(out1[6]), .IdExBubble(out1[5]),
        .ScndIteration(out1[4]), .IntPushPC(out1[3]), .IntPushFlags(out1[2]),
        .IntLoadVector(out1[1]), .IntAck(out1[0])
    );

    pipeline_hazard_sequencer #(.LOAD_USE_STALLS(3)) u_dut3 (
        .CLK(clk), .Reset(rst_n), .ExMemRead(ex_mem_read), .ExWB(ex_wb),
        .ExRdstAddress(ex_rdst), .ExJumpTaken(ex_jump), .IdValid(id_valid),
        .IdUsesRsrc(id_uses_rsrc), .IdUsesRdst(id_uses_rdst), .IdRsrcAddress(id_rsrc),
        .IdRdstAddress(id_rdst), .IdTwoCycle(id_two_cycle), .IntReq(int_req),
        .PcStall(out3[8]), .IfIdStall(out3[7]), .IfIdFlush(out3[6]), .IdExBubble(out3[5]),
        .ScndIteration(out3[4]), .IntPushPC(out3[3]), .IntPushFlags(out3[2]),
        .IntLoadVector(out3[1]), .IntAck(out3[0])
    );

    task automatic idle();
        ex_mem_read = 0; ex_wb = 0; ex_jump = 0; id_valid = 1; id_uses_rsrc = 0;
        id_uses_rdst = 0; id_two_cycle = 0; int_req = 0;
        ex_rdst = 3'd0; id_rsrc = 3'd0; id_rdst = 3'd0;
    endtask

    task automatic set_hazard(input logic [2:0] rsrc);
        ex_mem_read = 1; ex_wb = 1; ex_rdst = 3'd3; id_valid = 1;
        id_uses_rsrc = 1; id_rsrc = rsrc;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(); rst_n = 0; set_hazard(3'd3); ex_jump = 1; id_two_cycle = 1; int_req = 1;
        #2;
        if (out1 !== 9'h000) begin $display("FAIL reset_q1 got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        if (out3 !== 9'h000) begin $display("FAIL reset_q3 got=%b want=%b", out3, 9'h000); bad++; end
        total++;
        step(); idle();
        step(); rst_n = 1;
        #2;
        if (out1 !== 9'h000) begin $display("FAIL reset_run got=%b want=%b", out1, 9'h000); bad++; end
        total++;
    endtask

    task automatic test_load_use();
        step(); idle(); set_hazard(3'd4);
        #2;
        if (out1 !== 9'h000) begin $display("FAIL lu_addr_miss got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        step(); set_hazard(3'd3); ex_wb = 0;
        #2;
        if (out1 !== 9'h000) begin $display("FAIL lu_no_wb got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        step(); set_hazard(3'd3); id_valid = 0;
        #2;
        if (out3 !== 9'h000) begin $display("FAIL lu_id_invalid got=%b want=%b", out3, 9'h000); bad++; end
        total++;
        step(); set_hazard(3'd3);
        #2;
        exp = PS | IS | BB;
        if (out1 !== exp) begin $display("FAIL lu1_hit got=%b want=%b", out1, exp); bad++; end
        total++;
        if (out3 !== exp) begin $display("FAIL lu3_hit got=%b want=%b", out3, exp); bad++; end
        total++;
        step(); idle();
        #2;
        if (out1 !== 9'h000) begin $display("FAIL lu1_release got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        if (out3 !== exp) begin $display("FAIL lu3_wait1 got=%b want=%b", out3, exp); bad++; end
        total++;
        step();
        #2;
        if (out3 !== exp) begin $display("FAIL lu3_wait2 got=%b want=%b", out3, exp); bad++; end
        total++;
        step();
        #2;
        if (out3 !== 9'h000) begin $display("FAIL lu3_release got=%b want=%b", out3, 9'h000); bad++; end
        total++;
        // Rdst-side match only.
        step(); set_hazard(3'd0); id_uses_rsrc = 0; id_uses_rdst = 1; id_rdst = 3'd3;
        #2;
        if (out1 !== exp) begin $display("FAIL lu_rdst_hit got=%b want=%b", out1, exp); bad++; end
        total++;
        step(); idle();
        step();
        step();
    endtask

    task automatic test_jump();
        step(); set_hazard(3'd3); ex_jump = 1; id_two_cycle = 1;
        #2;
        exp = IF | BB;
        if (out1 !== exp) begin $display("FAIL jump_q1 got=%b want=%b", out1, exp); bad++; end
        total++;
        if (out3 !== exp) begin $display("FAIL jump_q3 got=%b want=%b", out3, exp); bad++; end
        total++;
        step(); idle();
        #2;
        if (out3 !== 9'h000) begin $display("FAIL jump_after got=%b want=%b", out3, 9'h000); bad++; end
        total++;
    endtask

    task automatic test_two_cycle();
        step(); idle(); id_two_cycle = 1; int_req = 1;
        #2;
        exp = PS | IS;
        if (out1 !== exp) begin $display("FAIL two_first got=%b want=%b", out1, exp); bad++; end
        total++;
        // Second pass ignores a hazard and the pending request.
        step(); idle(); id_two_cycle = 1; set_hazard(3'd3);
        #2;
        if (out1 !== SI) begin $display("FAIL two_second got=%b want=%b", out1, SI); bad++; end
        total++;
        if (out3 !== SI) begin $display("FAIL two_second3 got=%b want=%b", out3, SI); bad++; end
        total++;
        step(); idle();
        #2;
`ifdef INT_SEQ_EN
        exp = IF | PS;
        if (out1 !== exp) begin $display("FAIL two_int_accept got=%b want=%b", out1, exp); bad++; end
        total++;
        step();
        #2;
        exp = PP | PS | IF;
        if (out1 !== exp) begin $display("FAIL two_int_pushpc got=%b want=%b", out1, exp); bad++; end
        total++;
        step();
        step();
        step();
`else
        if (out1 !== 9'h000) begin $display("FAIL two_back_run got=%b want=%b", out1, 9'h000); bad++; end
        total++;
`endif
    endtask

`ifdef INT_SEQ_EN
    task automatic test_interrupt();
        step(); idle(); int_req = 1;
        #2;
        if (out1 !== 9'h000) begin $display("FAIL int_req_cycle got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        step(); idle();
        #2;
        exp = IF | PS;
        if (out1 !== exp) begin $display("FAIL int_accept got=%b want=%b", out1, exp); bad++; end
        total++;
        step(); int_req = 1;
        #2;
        exp = PP | PS | IF;
        if (out1 !== exp) begin $display("FAIL int_pushpc got=%b want=%b", out1, exp); bad++; end
        total++;
        step(); int_req = 0;
        #2;
        exp = PF | PS | IF;
        if (out3 !== exp) begin $display("FAIL int_pushflags got=%b want=%b", out3, exp); bad++; end
        total++;
        step();
        #2;
        exp = LV | AK | IF;
        if (out1 !== exp) begin $display("FAIL int_vector got=%b want=%b", out1, exp); bad++; end
        total++;
        // Request raised mid-sequence is serviced right after.
        step();
        #2;
        exp = IF | PS;
        if (out1 !== exp) begin $display("FAIL int_reaccept got=%b want=%b", out1, exp); bad++; end
        total++;
        step();
        step();
        #2;
        exp = PF | PS | IF;
        if (out1 !== exp) begin $display("FAIL int_abort_pre got=%b want=%b", out1, exp); bad++; end
        total++;
        rst_n = 0;
        #1;
        if (out1 !== 9'h000) begin $display("FAIL int_abort_zero got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        step();
        #2;
        if (out1 !== 9'h000) begin $display("FAIL int_abort_noack got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        step(); rst_n = 1;
        #2;
        if (out1 !== 9'h000) begin $display("FAIL int_abort_run got=%b want=%b", out1, 9'h000); bad++; end
        total++;
        step();
        #2;
        if (out1 !== 9'h000) begin $display("FAIL int_abort_run2 got=%b want=%b", out1, 9'h000); bad++; end
        total++;
    endtask
`else
    task automatic test_no_int();
        for (int i = 0; i < 10; i++) begin
            step(); idle(); int_req = 1;
            #2;
            if (out1 !== 9'h000) begin $display("FAIL noint_%0d got=%b want=%b", i, out1, 9'h000); bad++; end
            total++;
        end
        step(); idle();
        #2;
        if (out3 !== 9'h000) begin $display("FAIL noint_after got=%b want=%b", out3, 9'h000); bad++; end
        total++;
    endtask
`endif

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_load_use();
        test_jump();
        test_two_cycle();
`ifdef INT_SEQ_EN
        test_interrupt();
`else
        test_no_int();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
